// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR trap sequencer:
// CSR addresses, status/enable bit positions, cause codes and the sequencer state type.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MEIX           = 11;
  localparam int MTIX           = 7;

  localparam logic [4:0] CAUSE_MEI = 5'd11;
  localparam logic [4:0] CAUSE_MTI = 5'd7;

  typedef enum logic [2:0] {
    IDLE,
    T_MEPC,
    T_MIP,
    T_STATUS,
    T_JUMP,
    R_EPC,
    R_STATUS,
    R_JUMP
  } csr_seq_e;

  // Trap entry: stash MIE into MPIE, mask interrupts, record machine mode as previous privilege.
  function automatic logic [31:0] trap_status(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_status(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/csr_shadow.sv
// Local copies of mstatus and mie, kept coherent by snooping every write
// that reaches the CSR file, whether issued by the core or by the sequencer.
module csr_shadow
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] sh_mstatus,
  output logic [31:0] sh_mie
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_mstatus <= '0;
      sh_mie     <= '0;
    end else if (wr) begin
      if (addr == CSR_MSTATUS) sh_mstatus <= wdata;
      if (addr == CSR_MIE)     sh_mie     <= wdata;
    end
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Arbiter/sequencer for the single-port machine-mode CSR file: trap entry and mret.
// Define CSR_VECTORED_IRQ_EN to jump to VECTOR_BASE + cause*4 instead of VECTOR_BASE.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic [31:0] pc,
  input  logic        is_mret,
  input  logic        core_csr_rd,
  input  logic        core_csr_wr,
  input  logic [11:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        csr_rd,
  output logic        csr_wr,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  csr_seq_e    state, state_next;
  logic [31:0] sh_mstatus, sh_mie;
  logic [31:0] pc_q, epc_q;
  logic [4:0]  cause_q;
  logic        ext_q, tmr_q;
  logic        ext_en, tmr_en, take_trap, take_mret;
  logic [31:0] trap_target;
  logic        unused_mie;

  csr_shadow u_shadow (
    .clk        (clk),
    .rst        (rst),
    .wr         (csr_wr),
    .addr       (csr_addr),
    .wdata      (csr_wdata),
    .sh_mstatus (sh_mstatus),
    .sh_mie     (sh_mie)
  );

  assign unused_mie = ^{sh_mie[31:12], sh_mie[10:8], sh_mie[6:0]};

  assign ext_en    = irq_ext & sh_mie[MEIX];
  assign tmr_en    = irq_timer & sh_mie[MTIX];
  assign take_trap = ~rst & (state == IDLE) & sh_mstatus[MSTATUS_MIE] & (ext_en | tmr_en);
  assign take_mret = ~rst & (state == IDLE) & ~take_trap & is_mret;

`ifdef CSR_VECTORED_IRQ_EN
  assign trap_target = VECTOR_BASE + {25'b0, cause_q, 2'b0};
`else
  logic unused_cause;
  assign unused_cause = ^cause_q;
  assign trap_target  = VECTOR_BASE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Interrupt context is frozen in the IDLE cycle so lines dropping mid-sequence don't matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      epc_q   <= '0;
      cause_q <= '0;
      ext_q   <= 1'b0;
      tmr_q   <= 1'b0;
    end else begin
      if (take_trap) begin
        pc_q    <= pc;
        cause_q <= ext_en ? CAUSE_MEI : CAUSE_MTI;
        ext_q   <= ext_en;
        tmr_q   <= tmr_en;
      end
      if (state == R_EPC) epc_q <= csr_rdata;
    end
  end

  always_comb begin
    state_next  = state;
    core_rdata  = '0;
    csr_rd      = 1'b0;
    csr_wr      = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    stall       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    case (state)
      IDLE: begin
        if (take_trap) begin
          state_next = T_MEPC;
        end else if (take_mret) begin
          state_next = R_EPC;
        end else begin
          stall = 1'b0;
          if (!rst) begin
            csr_rd     = core_csr_rd;
            csr_wr     = core_csr_wr;
            csr_addr   = core_addr;
            csr_wdata  = core_wdata;
            core_rdata = csr_rdata;
          end
        end
      end
      T_MEPC: begin
        csr_wr     = 1'b1;
        csr_addr   = CSR_MEPC;
        csr_wdata  = pc_q;
        state_next = T_MIP;
      end
      T_MIP: begin
        csr_wr     = 1'b1;
        csr_addr   = CSR_MIP;
        csr_wdata  = {20'b0, ext_q, 3'b0, tmr_q, 7'b0};
        state_next = T_STATUS;
      end
      T_STATUS: begin
        csr_wr     = 1'b1;
        csr_addr   = CSR_MSTATUS;
        csr_wdata  = trap_status(sh_mstatus);
        state_next = T_JUMP;
      end
      T_JUMP: begin
        redirect    = 1'b1;
        redirect_pc = trap_target;
        state_next  = IDLE;
      end
      R_EPC: begin
        csr_rd     = 1'b1;
        csr_addr   = CSR_MEPC;
        state_next = R_STATUS;
      end
      R_STATUS: begin
        csr_wr     = 1'b1;
        csr_addr   = CSR_MSTATUS;
        csr_wdata  = mret_status(sh_mstatus);
        state_next = R_JUMP;
      end
      R_JUMP: begin
        redirect    = 1'b1;
        redirect_pc = epc_q;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Vector-table bench for csr_trap_ctrl with a behavioural CSR file attached;
// each table row is one clock cycle of inputs plus the outputs expected in that cycle.
module tb_csr_trap_ctrl;

  logic        clk, rst;
  logic        irq_ext, irq_timer, is_mret;
  logic [31:0] pc;
  logic        core_csr_rd, core_csr_wr;
  logic [11:0] core_addr;
  logic [31:0] core_wdata, core_rdata;
  logic        csr_rd, csr_wr;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        stall, redirect;
  logic [31:0] redirect_pc;

  int compared;
  int mismatched;

`ifdef CSR_VECTORED_IRQ_EN
  localparam logic [31:0] T_EXT = 32'h12C;
  localparam logic [31:0] T_TMR = 32'h11C;
`else
  localparam logic [31:0] T_EXT = 32'h100;
  localparam logic [31:0] T_TMR = 32'h100;
`endif

  typedef struct {
    logic        rst, ext, tmr, mret;
    logic [31:0] pc;
    logic        crd, cwr;
    logic [11:0] caddr;
    logic [31:0] cwdata;
    logic        e_stall, e_redir;
    logic [31:0] e_rpc;
    logic        e_rd, e_wr;
    logic [11:0] e_addr;
    logic [31:0] e_wdata, e_rdata;
  } vec_t;

  vec_t vecs[$];

  csr_trap_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .irq_ext     (irq_ext),
    .irq_timer   (irq_timer),
    .pc          (pc),
    .is_mret     (is_mret),
    .core_csr_rd (core_csr_rd),
    .core_csr_wr (core_csr_wr),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_rdata  (core_rdata),
    .csr_rd      (csr_rd),
    .csr_wr      (csr_wr),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  // Behavioural CSR file: asynchronous read, write on the clock edge, untouched by rst.
  logic [31:0] csr_mem [4096];
  initial for (int i = 0; i < 4096; i++) csr_mem[i] = '0;
  always @(posedge clk) if (csr_wr) csr_mem[csr_addr] <= csr_wdata;
  assign csr_rdata = csr_rd ? csr_mem[csr_addr] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  task automatic addVec(input logic r, input logic e, input logic t, input logic m, input logic [31:0] p,
                        input logic crd, input logic cwr, input logic [11:0] ca, input logic [31:0] cwd,
                        input logic es, input logic er, input logic [31:0] erpc,
                        input logic erd, input logic ewr, input logic [11:0] ea, input logic [31:0] ewd,
                        input logic [31:0] erdata);
    vec_t v;
    v.rst = r; v.ext = e; v.tmr = t; v.mret = m; v.pc = p;
    v.crd = crd; v.cwr = cwr; v.caddr = ca; v.cwdata = cwd;
    v.e_stall = es; v.e_redir = er; v.e_rpc = erpc;
    v.e_rd = erd; v.e_wr = ewr; v.e_addr = ea; v.e_wdata = ewd; v.e_rdata = erdata;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst         = v.rst;
    irq_ext     = v.ext;
    irq_timer   = v.tmr;
    is_mret     = v.mret;
    pc          = v.pc;
    core_csr_rd = v.crd;
    core_csr_wr = v.cwr;
    core_addr   = v.caddr;
    core_wdata  = v.cwdata;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    compare("stall",       idx, {31'b0, stall},    {31'b0, v.e_stall});
    compare("redirect",    idx, {31'b0, redirect}, {31'b0, v.e_redir});
    compare("redirect_pc", idx, redirect_pc,       v.e_rpc);
    compare("csr_rd",      idx, {31'b0, csr_rd},   {31'b0, v.e_rd});
    compare("csr_wr",      idx, {31'b0, csr_wr},   {31'b0, v.e_wr});
    compare("csr_addr",    idx, {20'b0, csr_addr}, {20'b0, v.e_addr});
    compare("csr_wdata",   idx, csr_wdata,         v.e_wdata);
    compare("core_rdata",  idx, core_rdata,        v.e_rdata);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b1; irq_ext = 0; irq_timer = 0; is_mret = 0; pc = '0;
    core_csr_rd = 0; core_csr_wr = 0; core_addr = '0; core_wdata = '0;

    //      rst e t m pc       rd wr addr    wdata      stl rdr rpc     rd wr addr    wdata     rdata
    // Reset: core port gated off, mret ignored
    addVec(1, 0,0,0, 32'h0,   0,1, 12'h300, 32'h8,     0,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);
    addVec(1, 0,0,1, 32'h0,   1,0, 12'h300, 32'h0,     0,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);
    // Enable external interrupt, then global MIE
    addVec(0, 0,0,0, 32'h0,   0,1, 12'h304, 32'h800,   0,0, 32'h0,   0,1, 12'h304, 32'h800,  32'h0);
    addVec(0, 0,0,0, 32'h0,   0,1, 12'h300, 32'h8,     0,0, 32'h0,   0,1, 12'h300, 32'h8,    32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     0,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);
    // External trap at pc 0x40; irq drops and pc changes mid-sequence
    addVec(0, 1,0,0, 32'h40,  1,0, 12'h300, 32'h0,     1,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);
    addVec(0, 0,0,0, 32'h99,  0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h341, 32'h40,   32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h344, 32'h800,  32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h300, 32'h1880, 32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,1, T_EXT,   0,0, 12'h000, 32'h0,    32'h0);
    // MIE now 0: irq ignored, read of mstatus passes through
    addVec(0, 1,0,0, 32'h0,   1,0, 12'h300, 32'h0,     0,0, 32'h0,   1,0, 12'h300, 32'h0,    32'h1880);
    // mret back to 0x40
    addVec(0, 0,0,1, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);
    addVec(0, 0,0,0, 32'h0,   1,0, 12'h300, 32'h0,     1,0, 32'h0,   1,0, 12'h341, 32'h0,    32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h300, 32'h1888, 32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,1, 32'h40,  0,0, 12'h000, 32'h0,    32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     0,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);
    // Both sources enabled and asserted: external wins
    addVec(0, 0,0,0, 32'h0,   0,1, 12'h304, 32'h880,   0,0, 32'h0,   0,1, 12'h304, 32'h880,  32'h0);
    addVec(0, 1,1,0, 32'h200, 0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);
    addVec(0, 1,1,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h341, 32'h200,  32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h344, 32'h880,  32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h300, 32'h1880, 32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,1, T_EXT,   0,0, 12'h000, 32'h0,    32'h0);
    addVec(0, 0,0,1, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   1,0, 12'h341, 32'h0,    32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h300, 32'h1888, 32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,1, 32'h200, 0,0, 12'h000, 32'h0,    32'h0);
    // Timer with MIE cleared: no sequence
    addVec(0, 0,0,0, 32'h0,   0,1, 12'h300, 32'h0,     0,0, 32'h0,   0,1, 12'h300, 32'h0,    32'h0);
    addVec(0, 0,1,0, 32'h0,   1,0, 12'h300, 32'h0,     0,0, 32'h0,   1,0, 12'h300, 32'h0,    32'h0);
    addVec(0, 0,1,0, 32'h0,   0,1, 12'h300, 32'h8,     0,0, 32'h0,   0,1, 12'h300, 32'h8,    32'h0);
    // Timer trap
    addVec(0, 0,1,0, 32'h300, 0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h341, 32'h300,  32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h344, 32'h80,   32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h300, 32'h1880, 32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,1, T_TMR,   0,0, 12'h000, 32'h0,    32'h0);
    // Trap and mret in the same cycle: trap first, held mret follows
    addVec(0, 0,0,0, 32'h0,   0,1, 12'h300, 32'h8,     0,0, 32'h0,   0,1, 12'h300, 32'h8,    32'h0);
    addVec(0, 1,0,1, 32'h44,  0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);
    addVec(0, 0,0,1, 32'h44,  0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h341, 32'h44,   32'h0);
    addVec(0, 0,0,1, 32'h44,  0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h344, 32'h800,  32'h0);
    addVec(0, 0,0,1, 32'h44,  0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h300, 32'h1880, 32'h0);
    addVec(0, 0,0,1, 32'h44,  0,0, 12'h000, 32'h0,     1,1, T_EXT,   0,0, 12'h000, 32'h0,    32'h0);
    addVec(0, 0,0,1, 32'h44,  0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   1,0, 12'h341, 32'h0,    32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h300, 32'h1888, 32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,1, 32'h44,  0,0, 12'h000, 32'h0,    32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     0,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);
    // Reset while in T_STATUS: no redirect, shadows cleared, CSR file keeps mie
    addVec(0, 1,0,0, 32'h80,  0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h341, 32'h80,   32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h344, 32'h800,  32'h0);
    addVec(1, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     0,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);
    addVec(0, 1,0,0, 32'h84,  0,0, 12'h000, 32'h0,     0,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);
    addVec(0, 1,0,0, 32'h84,  1,0, 12'h304, 32'h0,     0,0, 32'h0,   1,0, 12'h304, 32'h0,    32'h880);
    addVec(0, 1,0,0, 32'h84,  0,1, 12'h304, 32'h800,   0,0, 32'h0,   0,1, 12'h304, 32'h800,  32'h0);
    addVec(0, 1,0,0, 32'h84,  0,1, 12'h300, 32'h8,     0,0, 32'h0,   0,1, 12'h300, 32'h8,    32'h0);
    addVec(0, 1,0,0, 32'h90,  0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h341, 32'h90,   32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h344, 32'h800,  32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,0, 32'h0,   0,1, 12'h300, 32'h1880, 32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     1,1, T_EXT,   0,0, 12'h000, 32'h0,    32'h0);
    addVec(0, 0,0,0, 32'h0,   0,0, 12'h000, 32'h0,     0,0, 32'h0,   0,0, 12'h000, 32'h0,    32'h0);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    // CSR file contents left behind by the final trap sequence
    compare("mem_mepc",    -1, csr_mem[12'h341], 32'h90);
    compare("mem_mip",     -1, csr_mem[12'h344], 32'h800);
    compare("mem_mstatus", -1, csr_mem[12'h300], 32'h1880);
    compare("mem_mie",     -1, csr_mem[12'h304], 32'h800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Sequencer and arbiter for the machine-mode CSR file, which has a single read/write port. It sits between the datapath's CSR-instruction port and the CSR file and multiplexes that one port between core accesses and its own multi-cycle sequences. On an enabled interrupt it saves the PC, records pending bits, updates the status fields and redirects fetch to the handler. On `mret` it restores status and redirects fetch to the saved EPC.

## Interface
- `VECTOR_BASE`, default 32'h0000_0100: handler base address.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `irq_ext`  in  1: external interrupt request, level.
- `irq_timer`  in  1: timer interrupt request, level.
- `pc`  in  32: PC of the instruction in execute.
- `is_mret`  in  1: execute-stage instruction is `mret`.
- `core_csr_rd`, `core_csr_wr`  in  1 each: CSR-instruction read/write strobes from the datapath.
- `core_addr`  in  12: CSR address from the datapath.
- `core_wdata`  in  32: CSR write data from the datapath.
- `core_rdata`  out  32: CSR read data returned to the datapath.
- `csr_rd`, `csr_wr`  out  1 each: read/write strobes to the CSR file.
- `csr_addr`  out  12: address to the CSR file.
- `csr_wdata`  out  32: write data to the CSR file.
- `csr_rdata`  in  32: asynchronous read data from the CSR file.
- `stall`  out  1: freezes PC and pipeline registers.
- `redirect`  out  1: one-cycle fetch redirect.
- `redirect_pc`  out  32: redirect target.

## Operation
- States: IDLE, T_MEPC, T_MIP, T_STATUS, T_JUMP, R_EPC, R_STATUS, R_JUMP.
- Shadow registers `sh_mstatus` and `sh_mie` (reset 0) capture every `csr_wr` to 0x300 and 0x304 at the clock edge, whichever source issued it.
- Enabled interrupt lines: `ext_en = irq_ext & sh_mie[11]`, `tmr_en = irq_timer & sh_mie[7]`.
- `take_trap = (state==IDLE) & sh_mstatus[3] & (ext_en | tmr_en)`.
- Cause priority: external (11) over timer (7). Latched into `cause_q` in the IDLE cycle.
- `take_mret = (state==IDLE) & ~take_trap & is_mret`. A trap beats an `mret`.
- IDLE, neither taken: the core port passes straight through (`csr_*` = `core_*`, `core_rdata` = `csr_rdata`). `stall`=0, `redirect`=0.
- IDLE, trap or mret taken: `stall`=1 and the core strobes are suppressed. The stalled instruction re-issues afterwards.
- T_MEPC: write 0x341 ← `pc_q`, where `pc_q` is `pc` latched in the IDLE cycle.
- T_MIP: write 0x344 ← {20'b0, ext_en, 3'b0, tmr_en, 7'b0}, i.e. bit 11 and bit 7, values latched in the IDLE cycle.
- T_STATUS: write 0x300 ← `sh_mstatus` with the following changes:
  - bit 7 (MPIE) ← bit 3 (MIE);
  - bit 3 ← 0;
  - bits 12:11 (MPP) ← 2'b11.
- T_JUMP: `redirect`=1, `redirect_pc` = target, then go to IDLE.
- R_EPC: `csr_rd`=1 at 0x341; `epc_q` ← `csr_rdata` at the edge.
- R_STATUS: write 0x300 ← `sh_mstatus` with bit 3 ← bit 7 and bit 7 ← 1.
- R_JUMP: `redirect`=1, `redirect_pc` = `epc_q`, then go to IDLE.
- Outside IDLE: `core_rdata`=0 and `stall`=1.
- Reset mid-sequence: go to IDLE and clear shadows, `pc_q`, `epc_q` and `cause_q`. No redirect is issued. The CSR file keeps its contents; interrupts stay masked until software rewrites mie and mstatus.

## Timing
- Reset values:
  - `stall`, `redirect`, `csr_rd`, `csr_wr` = 0.
  - `redirect_pc`, `csr_addr`, `csr_wdata`, `core_rdata` = 0.
  - While `rst` is high, the core pass-through is gated off.
- Trap detected in cycle N:
  - mepc write in N+1, mip write in N+2, mstatus write in N+3.
  - `redirect` in N+4.
  - `stall` high N..N+4 (5 cycles).
- `mret` detected in cycle N: read in N+1, mstatus write in N+2, `redirect` in N+3. `stall` high N..N+3.
- Interrupt lines are sampled only in IDLE. A request that drops mid-sequence does not abort the sequence.
- Back-to-back: the earliest next trap is N+5, and it is taken only if software re-enabled MIE. Hardware MIE=0 prevents nesting.
- `redirect` is a single-cycle pulse. `redirect_pc` is 0 whenever `redirect`=0.

## Configuration
- `CSR_VECTORED_IRQ_EN` defined: trap target = `VECTOR_BASE + (cause_q << 2)`, giving +0x2C for external and +0x1C for timer.
- `CSR_VECTORED_IRQ_EN` undefined: trap target = `VECTOR_BASE` for all causes. `cause_q` is still latched but unused.

## Structure
- Package `csr_pkg` holds:
  - CSR addresses `CSR_MSTATUS`/`CSR_MIE`/`CSR_MEPC`/`CSR_MIP`;
  - bit indices MIE=3, MPIE=7, MPP=12:11, MEIx=11, MTIx=7;
  - cause codes `CAUSE_MEI`=11 and `CAUSE_MTI`=7;
  - the FSM state enum `csr_seq_e`.
- One sub-module, `csr_shadow`: it snoops the `csr_*` write port and holds `sh_mstatus`/`sh_mie` with asynchronous reset.

## Test plan
- Core write 0x304←0x800 and 0x300←0x8, then `irq_ext`=1 with `pc`=0x40 → mepc=0x40, mip=0x800, mstatus=0x1880, `redirect_pc`=0x100 (0x12C with macro), stall for 5 cycles.
- Then `is_mret` → mstatus=0x1888, `redirect` to 0x40 at N+3, stall for 4 cycles.
- `irq_ext` and `irq_timer` both enabled and asserted → mip=0x880, cause 11 chosen, vectored target 0x12C.
- `irq_timer`=1 with mstatus.MIE=0 → no sequence, core CSR read of 0x300 returns 0 with stall=0.
- `irq_ext` and `is_mret` asserted in the same IDLE cycle → trap sequence runs, `mret` waits (stall holds it), then runs.
- `rst` asserted in T_STATUS → state IDLE, no `redirect`, shadows 0, a later `irq_ext` is ignored until mie/mstatus are rewritten.
